ddr4_cal_rd_cas_sched: RTL and testbench

Read-CAS scheduler that sits in front of the read-enable/read-rank generator in the calibration/MC path. It arbitrates read-CAS requests from the calibration sequencer and from the memory controller. It enforces same-rank and rank-switch spacing in fabric cycles and drives the downstream read-CAS strobe, the winning rank and the CAS slot, so that downstream gate-enable gaps and rank-select holds are never violated.

---
 rtl/ddr4_cal_rd_cas_sched.sv | 117 +++++++++++
 tb/tb_ddr4_cal_rd_cas_sched.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ddr4_cal_rd_cas_sched.sv
// Read-CAS scheduler: arbitrates calibration and MC read-CAS requests, enforcing
// same-rank / rank-switch spacing, and drives registered rdCAS, rank and slot.
module ddr4_cal_rd_cas_sched #(
  parameter int unsigned RANKS           = 1,
  parameter int unsigned SAME_RANK_GAP   = 1,
  parameter int unsigned RANK_SWITCH_GAP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       calDone,
  input  logic       cal_req,
  input  logic [1:0] cal_rank,
  output logic       cal_gnt,
  input  logic       mc_req,
  input  logic [1:0] mc_rank,
  input  logic       mc_slot2,
  output logic       mc_gnt,
  output logic       rdCAS,
  output logic       calrdCAS,
  output logic       mcrdCAS,
  output logic [1:0] winRank,
  output logic [1:0] casSlot,
  output logic       mccasSlot2
);

  localparam int unsigned CntW = 4;
  localparam int unsigned GapW = 5;
  localparam logic [CntW-1:0] CntMax = '1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      last_rank_q, last_rank_d;
  logic            last_slot2_q, last_slot2_d;
  logic            rr_q, rr_d;
  logic            cal_gnt_q, cal_gnt_d;
  logic            mc_gnt_q, mc_gnt_d;
  logic [1:0]      win_rank_q, win_rank_d;
  logic            slot2_q, slot2_d;

  logic [1:0] cal_rank_eff, mc_rank_eff;
  logic       cal_ok, mc_ok, pick_cal, pick_mc;

  // Widened to 5 bits so cnt=15 plus one cannot wrap.
  function automatic logic gap_ok(input logic [1:0] rank, input logic [1:0] lrank,
                                  input logic lslot2, input logic [CntW-1:0] cnt);
    logic [GapW-1:0] gap;
    if (RANKS == 1 || rank == lrank) gap = GapW'(SAME_RANK_GAP);
    else                             gap = GapW'(RANK_SWITCH_GAP) + GapW'(lslot2);
    return (GapW'(cnt) + GapW'(1)) >= gap;
  endfunction

  always_comb begin
    cal_rank_eff = (RANKS == 1) ? 2'b00 : cal_rank;
    mc_rank_eff  = (RANKS == 1) ? 2'b00 : mc_rank;
    cal_ok   = cal_req && !cal_gnt_q && gap_ok(cal_rank_eff, last_rank_q, last_slot2_q, cnt_q);
    mc_ok    = mc_req && calDone && !mc_gnt_q &&
               gap_ok(mc_rank_eff, last_rank_q, last_slot2_q, cnt_q);
    pick_cal = cal_ok && (!mc_ok || !rr_q);
    pick_mc  = mc_ok && !pick_cal;

    cnt_d        = (cnt_q == CntMax) ? CntMax : cnt_q + CntW'(1);
    last_rank_d  = last_rank_q;
    last_slot2_d = last_slot2_q;
    rr_d         = rr_q;
    cal_gnt_d    = 1'b0;
    mc_gnt_d     = 1'b0;
    win_rank_d   = 2'b00;
    slot2_d      = 1'b0;

    if (cal_ok && mc_ok) rr_d = pick_cal;
    if (pick_cal) begin
      cal_gnt_d    = 1'b1;
      win_rank_d   = cal_rank_eff;
      cnt_d        = '0;
      last_rank_d  = cal_rank_eff;
      last_slot2_d = 1'b0;
    end else if (pick_mc) begin
      mc_gnt_d     = 1'b1;
      win_rank_d   = mc_rank_eff;
      slot2_d      = mc_slot2;
      cnt_d        = '0;
      last_rank_d  = mc_rank_eff;
      last_slot2_d = mc_slot2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= CntMax;
      last_rank_q  <= 2'b00;
      last_slot2_q <= 1'b0;
      rr_q         <= 1'b0;
      cal_gnt_q    <= 1'b0;
      mc_gnt_q     <= 1'b0;
      win_rank_q   <= 2'b00;
      slot2_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      last_rank_q  <= last_rank_d;
      last_slot2_q <= last_slot2_d;
      rr_q         <= rr_d;
      cal_gnt_q    <= cal_gnt_d;
      mc_gnt_q     <= mc_gnt_d;
      win_rank_q   <= win_rank_d;
      slot2_q      <= slot2_d;
    end
  end

  assign cal_gnt    = cal_gnt_q;
  assign mc_gnt     = mc_gnt_q;
  assign rdCAS      = cal_gnt_q | mc_gnt_q;
  assign calrdCAS   = cal_gnt_q;
  assign mcrdCAS    = mc_gnt_q;
  assign winRank    = win_rank_q;
  assign casSlot    = {slot2_q, 1'b0};
  assign mccasSlot2 = slot2_q;

endmodule

// File: tb/tb_ddr4_cal_rd_cas_sched.sv
// Directed bench for ddr4_cal_rd_cas_sched: a 4-rank and a 1-rank instance share stimulus.
module tb_ddr4_cal_rd_cas_sched;

  logic clk = 1'b0;
  logic rst, calDone, cal_req, mc_req, mc_slot2;
  logic [1:0] cal_rank, mc_rank;

  logic a_cal_gnt, a_mc_gnt, a_rdcas, a_calrd, a_mcrd, a_slot2;
  logic [1:0] a_rank, a_slot;
  logic b_cal_gnt, b_mc_gnt, b_rdcas, b_calrd, b_mcrd, b_slot2;
  logic [1:0] b_rank, b_slot;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ddr4_cal_rd_cas_sched #(.RANKS(4), .SAME_RANK_GAP(1), .RANK_SWITCH_GAP(2)) u_dut4 (
    .clk(clk), .rst(rst), .calDone(calDone),
    .cal_req(cal_req), .cal_rank(cal_rank), .cal_gnt(a_cal_gnt),
    .mc_req(mc_req), .mc_rank(mc_rank), .mc_slot2(mc_slot2), .mc_gnt(a_mc_gnt),
    .rdCAS(a_rdcas), .calrdCAS(a_calrd), .mcrdCAS(a_mcrd),
    .winRank(a_rank), .casSlot(a_slot), .mccasSlot2(a_slot2));

  ddr4_cal_rd_cas_sched #(.RANKS(1), .SAME_RANK_GAP(1), .RANK_SWITCH_GAP(2)) u_dut1 (
    .clk(clk), .rst(rst), .calDone(calDone),
    .cal_req(cal_req), .cal_rank(cal_rank), .cal_gnt(b_cal_gnt),
    .mc_req(mc_req), .mc_rank(mc_rank), .mc_slot2(mc_slot2), .mc_gnt(b_mc_gnt),
    .rdCAS(b_rdcas), .calrdCAS(b_calrd), .mcrdCAS(b_mcrd),
    .winRank(b_rank), .casSlot(b_slot), .mccasSlot2(b_slot2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Outputs are sampled 1 time unit after the edge, away from the active edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int first_a, first_b, mc_seen;

  initial begin
    rst = 1'b1; calDone = 1'b0; cal_req = 1'b0; mc_req = 1'b0;
    cal_rank = 2'd0; mc_rank = 2'd0; mc_slot2 = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);
    check("idle_rdcas", 32'(a_rdcas), 32'd0);
    check("idle_gnts",  32'({a_cal_gnt, a_mc_gnt, a_calrd, a_mcrd}), 32'd0);
    check("idle_rank_slot", 32'({a_rank, a_slot, a_slot2}), 32'd0);

    // Calibration request before calDone: 1-cycle latency, single pulse.
    cal_req = 1'b1; cal_rank = 2'd1;
    tick();
    check("cal_gnt",     32'(a_cal_gnt), 32'd1);
    check("cal_rdcas",   32'({a_rdcas, a_calrd, a_mcrd}), 32'b110);
    check("cal_winrank", 32'(a_rank), 32'd1);
    check("cal_casslot", 32'({a_slot, a_slot2}), 32'd0);
    check("r1_winrank",  32'({b_cal_gnt, b_rank}), 32'b100);
    cal_req = 1'b0;
    tick();
    check("cal_one_pulse", 32'({a_cal_gnt, a_rdcas}), 32'd0);

    // MC masked while calDone is low.
    mc_req = 1'b1; mc_rank = 2'd0; mc_slot2 = 1'b0;
    mc_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (a_mc_gnt) mc_seen++;
    end
    check("mc_masked", 32'(mc_seen), 32'd0);
    calDone = 1'b1;
    tick();
    check("mc_gnt_after_caldone", 32'({a_mc_gnt, a_mcrd, a_rdcas, a_calrd}), 32'b1110);
    check("mc_slot0", 32'({a_slot, a_slot2}), 32'd0);
    mc_req = 1'b0;
    tick(20);

    // Rank switch after an MC slot2 CAS: cal rank2 needs 2+1 cycles.
    mc_req = 1'b1; mc_rank = 2'd0; mc_slot2 = 1'b1;
    tick();
    check("mc_slot2_gnt", 32'({a_mc_gnt, a_slot, a_slot2}), 32'b1101);
    mc_req = 1'b0; mc_slot2 = 1'b0;
    cal_req = 1'b1; cal_rank = 2'd2;
    first_a = 0; first_b = 0;
    for (int i = 1; i <= 8 && first_a == 0; i++) begin
      tick();
      if (b_cal_gnt && first_b == 0) begin
        first_b = i;
        check("r1_rank_forced0", 32'(b_rank), 32'd0);
      end
      if (a_cal_gnt) begin
        first_a = i;
        check("switch_winrank", 32'(a_rank), 32'd2);
        cal_req = 1'b0;
      end
    end
    check("switch_gap_slot2", 32'(first_a), 32'd3);
    check("r1_same_rank_gap", 32'(first_b), 32'd1);
    cal_req = 1'b0;
    tick(20);

    // Rank switch after an MC slot0 CAS: 2 cycles.
    mc_req = 1'b1; mc_rank = 2'd0; mc_slot2 = 1'b0;
    tick();
    check("mc_slot0_gnt", 32'(a_mc_gnt), 32'd1);
    mc_req = 1'b0;
    cal_req = 1'b1; cal_rank = 2'd2;
    first_a = 0;
    for (int i = 1; i <= 8 && first_a == 0; i++) begin
      tick();
      if (a_cal_gnt) begin
        first_a = i;
        cal_req = 1'b0;
      end
    end
    check("switch_gap_slot0", 32'(first_a), 32'd2);
    cal_req = 1'b0;
    tick(20);

    // Both requesting rank0 continuously: cal, mc, cal, mc ...
    cal_req = 1'b1; cal_rank = 2'd0;
    mc_req = 1'b1; mc_rank = 2'd0; mc_slot2 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("alt_cal_%0d", i), 32'(a_cal_gnt), 32'(i % 2));
      check($sformatf("alt_mc_%0d", i),  32'(a_mc_gnt),  32'((i + 1) % 2));
    end
    cal_req = 1'b0; mc_req = 1'b0;
    tick(3);

    // calDone falling re-masks MC immediately.
    calDone = 1'b0; mc_req = 1'b1;
    mc_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (a_mc_gnt) mc_seen++;
    end
    check("mc_remasked", 32'(mc_seen), 32'd0);
    mc_req = 1'b0; calDone = 1'b1;
    tick(3);

    // Reset during a decision drops the pulse; afterwards rr=0 and cnt=15.
    rst = 1'b1; cal_req = 1'b1; cal_rank = 2'd1;
    mc_req = 1'b1; mc_rank = 2'd1;
    tick();
    check("rst_no_rdcas", 32'({a_rdcas, a_cal_gnt, a_mc_gnt}), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_cal_first", 32'({a_cal_gnt, a_mc_gnt, a_rdcas}), 32'b101);
    check("post_rst_rank", 32'(a_rank), 32'd1);
    cal_req = 1'b0; mc_req = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
